// File: rtl/ma_pkg.sv
// Shared types and helpers for the ma_conv_engine multiply-accumulate block.
// Holds the FSM state codes, beat/width helpers and the result-narrowing function.
package ma_pkg;

    localparam int MAX_ACC_W    = 128;
    localparam int MAX_NARROW_W = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_MAC    = 2'd1;
    localparam state_t ST_NARROW = 2'd2;
    localparam state_t ST_OUT    = 2'd3;

    typedef struct packed {
        logic [MAX_NARROW_W-1:0] value;
        logic                    overflow;
    } narrow_t;

    function automatic int beats(input int n, input int lanes);
        return (n + lanes - 1) / lanes;
    endfunction

    function automatic int acc_width(input int dw, input int n, input int channels);
        return 2 * dw + $clog2(n * channels);
    endfunction

    // Range check always flags overflow; the value clamps only when saturate is set.
    function automatic narrow_t narrow_value(input logic signed [MAX_ACC_W-1:0] r,
                                             input int dw, input bit saturate);
        logic signed [MAX_ACC_W-1:0] one;
        logic signed [MAX_ACC_W-1:0] hi;
        logic signed [MAX_ACC_W-1:0] lo;
        narrow_t res;
        one          = MAX_ACC_W'(1);
        hi           = (one <<< (dw - 1)) - one;
        lo           = ~hi;
        res.overflow = (r > hi) || (r < lo);
        res.value    = r[MAX_NARROW_W-1:0];
        if (saturate && (r > hi)) begin
            res.value = hi[MAX_NARROW_W-1:0];
        end else if (saturate && (r < lo)) begin
            res.value = lo[MAX_NARROW_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/ma_conv_engine_if.sv
// Window-in / result-out handshake bundle for ma_conv_engine.
// The engine connects to the slave modport; the producer/consumer uses master.
interface ma_conv_engine_if #(
    parameter int DATA_WIDTH = 32,
    parameter int N          = 9
);
    logic                      in_valid;
    logic                      in_ready;
    logic [N*DATA_WIDTH-1:0]   multiplier_input;
    logic [N*DATA_WIDTH-1:0]   multiplicand_input;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_WIDTH-1:0]     finalAccumulate;
    logic                      overflow;

    modport master (
        output in_valid, multiplier_input, multiplicand_input, out_ready,
        input  in_ready, out_valid, finalAccumulate, overflow
    );

    modport slave (
        input  in_valid, multiplier_input, multiplicand_input, out_ready,
        output in_ready, out_valid, finalAccumulate, overflow
    );
endinterface

// File: rtl/ma_dot_lane.sv
// Combinational LANES-wide signed dot product, sign-extended to ACC_WIDTH.
module ma_dot_lane #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 3,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH + 4
) (
    input  logic [LANES*DATA_WIDTH-1:0] a_i,
    input  logic [LANES*DATA_WIDTH-1:0] b_i,
    output logic signed [ACC_WIDTH-1:0] sum_o
);

    logic signed [2*DATA_WIDTH-1:0] prod;

    always_comb begin
        sum_o = '0;
        prod  = '0;
        for (int i = 0; i < LANES; i++) begin
            prod  = (2*DATA_WIDTH)'(signed'(a_i[i*DATA_WIDTH +: DATA_WIDTH]))
                  * (2*DATA_WIDTH)'(signed'(b_i[i*DATA_WIDTH +: DATA_WIDTH]));
            sum_o = sum_o + ACC_WIDTH'(prod);
        end
    end

endmodule

// File: rtl/ma_conv_engine.sv
// Handshaked multiply-accumulate engine over KERNEL_SIZE^2 windows, LANES products per beat.
// Define MA_SATURATE_EN to clamp out-of-range results; otherwise results wrap.
module ma_conv_engine
    import ma_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int KERNEL_SIZE = 3,
    parameter int LANES       = 3,
    parameter int CHANNELS    = 1,
    parameter int FRAC_BITS   = 0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    ma_conv_engine_if.slave  bus,
    output logic             busy_o
);

    localparam int N         = KERNEL_SIZE * KERNEL_SIZE;
    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, N, CHANNELS);
    localparam int BEATS     = beats(N, LANES);
    localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CHAN_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int LANE_W    = LANES * DATA_WIDTH;
    localparam int PAD_W     = BEATS * LANE_W;
`ifdef MA_SATURATE_EN
    localparam bit SATURATE  = 1'b1;
`else
    localparam bit SATURATE  = 1'b0;
`endif

    state_t                       state_q, state_d;
    logic [BEAT_W-1:0]            beat_q, beat_d;
    logic [CHAN_W-1:0]            chan_q, chan_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [N*DATA_WIDTH-1:0]      mul_q, mul_d, mcd_q, mcd_d;
    logic [DATA_WIDTH-1:0]        final_q, final_d;
    logic                         ovf_q, ovf_d;

    logic [PAD_W-1:0]             mulPad, mcdPad;
    logic [LANE_W-1:0]            laneMul, laneMcd;
    logic signed [ACC_WIDTH-1:0]  laneSum;
    logic signed [ACC_WIDTH-1:0]  shifted;
    logic signed [MAX_ACC_W-1:0]  shiftedWide;
    narrow_t                      narrowed;
    logic                         inReady;

    // Zero-filled padding makes a partial last beat contribute nothing.
    always_comb begin
        mulPad                    = '0;
        mcdPad                    = '0;
        mulPad[N*DATA_WIDTH-1:0]  = mul_q;
        mcdPad[N*DATA_WIDTH-1:0]  = mcd_q;
        laneMul                   = mulPad[int'(beat_q)*LANE_W +: LANE_W];
        laneMcd                   = mcdPad[int'(beat_q)*LANE_W +: LANE_W];
    end

    ma_dot_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_dot_lane (
        .a_i   (laneMul),
        .b_i   (laneMcd),
        .sum_o (laneSum)
    );

    assign shifted     = acc_q >>> FRAC_BITS;
    assign shiftedWide = MAX_ACC_W'(shifted);
    assign narrowed    = narrow_value(shiftedWide, DATA_WIDTH, SATURATE);
    assign inReady     = (state_q == ST_IDLE) && !clear_i;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        chan_d  = chan_q;
        acc_d   = acc_q;
        mul_d   = mul_q;
        mcd_d   = mcd_q;
        final_d = final_q;
        ovf_d   = ovf_q;
        if (clear_i) begin
            state_d = ST_IDLE;
            beat_d  = '0;
            chan_d  = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        mul_d   = bus.multiplier_input;
                        mcd_d   = bus.multiplicand_input;
                        beat_d  = '0;
                        state_d = ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc_d = acc_q + laneSum;
                    if (int'(beat_q) == BEATS - 1) begin
                        beat_d = '0;
                        // Non-final channels park in IDLE with the sum held.
                        if (int'(chan_q) < CHANNELS - 1) begin
                            chan_d  = chan_q + 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_NARROW;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
                ST_NARROW: begin
                    final_d = narrowed.value[DATA_WIDTH-1:0];
                    ovf_d   = narrowed.overflow;
                    state_d = ST_OUT;
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        acc_d   = '0;
                        chan_d  = '0;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            chan_q  <= '0;
            acc_q   <= '0;
            mul_q   <= '0;
            mcd_q   <= '0;
            final_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            chan_q  <= chan_d;
            acc_q   <= acc_d;
            mul_q   <= mul_d;
            mcd_q   <= mcd_d;
            final_q <= final_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready        = inReady;
    assign bus.out_valid       = (state_q == ST_OUT);
    assign bus.finalAccumulate = final_q;
    assign bus.overflow        = ovf_q;
    assign busy_o              = (state_q != ST_IDLE) || (chan_q != '0);

endmodule

// File: tb/tb_ma_conv_engine.sv
// Bench for ma_conv_engine: four configurations share clock, reset and clear.
// Expected results come from a dot-product/narrowing model plus literal checks.
module tb_ma_conv_engine;

    typedef struct {
        logic [63:0] val;
        logic        ovf;
        int          acceptCycle;
    } expItem_t;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    logic busyA, busyB, busyC, busyD;

    int totalChecks = 0;
    int passCount   = 0;
    int cycleCnt    = 0;

    int dwOf[4]   = '{32, 32, 8, 16};
    int fracOf[4] = '{0, 0, 0, 8};
    int chanOf[4] = '{1, 2, 1, 1};
    int latOf[4]  = '{4, 6, 4, 4};

    logic signed [127:0] modelSum[4];
    int                  chanCnt[4];
    int                  lastAccept[4];
    bit                  firstSeen[4];
    expItem_t            expQ[4][$];

    int winM[9];
    int winC[9];

    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    ma_conv_engine_if #(.DATA_WIDTH(32), .N(9)) ifA ();
    ma_conv_engine_if #(.DATA_WIDTH(32), .N(9)) ifB ();
    ma_conv_engine_if #(.DATA_WIDTH(8),  .N(9)) ifC ();
    ma_conv_engine_if #(.DATA_WIDTH(16), .N(9)) ifD ();

    ma_conv_engine #(.DATA_WIDTH(32), .KERNEL_SIZE(3), .LANES(3), .CHANNELS(1), .FRAC_BITS(0))
        dutA (.clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .bus(ifA.slave), .busy_o(busyA));
    ma_conv_engine #(.DATA_WIDTH(32), .KERNEL_SIZE(3), .LANES(2), .CHANNELS(2), .FRAC_BITS(0))
        dutB (.clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .bus(ifB.slave), .busy_o(busyB));
    ma_conv_engine #(.DATA_WIDTH(8), .KERNEL_SIZE(3), .LANES(3), .CHANNELS(1), .FRAC_BITS(0))
        dutC (.clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .bus(ifC.slave), .busy_o(busyC));
    ma_conv_engine #(.DATA_WIDTH(16), .KERNEL_SIZE(3), .LANES(3), .CHANNELS(1), .FRAC_BITS(8))
        dutD (.clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .bus(ifD.slave), .busy_o(busyD));

    function automatic logic [63:0] finalOf(input int i);
        case (i)
            0: return 64'(ifA.finalAccumulate);
            1: return 64'(ifB.finalAccumulate);
            2: return 64'(ifC.finalAccumulate);
            default: return 64'(ifD.finalAccumulate);
        endcase
    endfunction

    function automatic logic validOf(input int i);
        case (i)
            0: return ifA.out_valid;
            1: return ifB.out_valid;
            2: return ifC.out_valid;
            default: return ifD.out_valid;
        endcase
    endfunction

    function automatic logic readyOf(input int i);
        case (i)
            0: return ifA.in_ready;
            1: return ifB.in_ready;
            2: return ifC.in_ready;
            default: return ifD.in_ready;
        endcase
    endfunction

    function automatic logic ovfOf(input int i);
        case (i)
            0: return ifA.overflow;
            1: return ifB.overflow;
            2: return ifC.overflow;
            default: return ifD.overflow;
        endcase
    endfunction

    function automatic logic outReadyOf(input int i);
        case (i)
            0: return ifA.out_ready;
            1: return ifB.out_ready;
            2: return ifC.out_ready;
            default: return ifD.out_ready;
        endcase
    endfunction

    function automatic logic busyOf(input int i);
        case (i)
            0: return busyA;
            1: return busyB;
            2: return busyC;
            default: return busyD;
        endcase
    endfunction

    function automatic logic [287:0] packWin(input int e[9], input int dw);
        logic [287:0] v;
        logic [31:0]  t;
        v = '0;
        for (int k = 0; k < 9; k++) begin
            t = e[k];
            for (int b = 0; b < dw; b++) v[k*dw + b] = t[b];
        end
        return v;
    endfunction

    // Spec-level result: shift the exact sum, range-check, then clamp or wrap to dw bits.
    function automatic expItem_t modelResult(input logic signed [127:0] sum, input int dw,
                                             input int frac, input int acc);
        expItem_t e;
        logic signed [127:0] r, hi, lo, v;
        logic [63:0] mask;
        r     = sum >>> frac;
        hi    = (128'sd1 <<< (dw - 1)) - 128'sd1;
        lo    = -(128'sd1 <<< (dw - 1));
        e.ovf = (r > hi) || (r < lo);
        v     = r;
`ifdef MA_SATURATE_EN
        if (r > hi) v = hi;
        else if (r < lo) v = lo;
`endif
        mask          = (64'd1 << dw) - 64'd1;
        e.val         = v[63:0] & mask;
        e.acceptCycle = acc;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        totalChecks++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic driveIn(input int i, input logic v, input logic [287:0] pm,
                           input logic [287:0] pc);
        case (i)
            0: begin ifA.in_valid = v; ifA.multiplier_input = pm; ifA.multiplicand_input = pc; end
            1: begin ifB.in_valid = v; ifB.multiplier_input = pm; ifB.multiplicand_input = pc; end
            2: begin ifC.in_valid = v; ifC.multiplier_input = pm[71:0]; ifC.multiplicand_input = pc[71:0]; end
            default: begin ifD.in_valid = v; ifD.multiplier_input = pm[143:0]; ifD.multiplicand_input = pc[143:0]; end
        endcase
    endtask

    task automatic setOutReady(input int i, input logic r);
        case (i)
            0: ifA.out_ready = r;
            1: ifB.out_ready = r;
            2: ifC.out_ready = r;
            default: ifD.out_ready = r;
        endcase
    endtask

    task automatic flushModel();
        for (int i = 0; i < 4; i++) begin
            modelSum[i]  = '0;
            chanCnt[i]   = 0;
            firstSeen[i] = 1'b0;
            expQ[i].delete();
        end
    endtask

    task automatic fillWin(input int mv, input int cv);
        for (int k = 0; k < 9; k++) begin
            winM[k] = mv;
            winC[k] = cv;
        end
    endtask

    task automatic applyStimulus(input int i);
        logic signed [127:0] dot;
        bit got;
        dot = '0;
        for (int k = 0; k < 9; k++) dot = dot + 128'(longint'(winM[k]) * longint'(winC[k]));
        @(negedge clk);
        driveIn(i, 1'b1, packWin(winM, dwOf[i]), packWin(winC, dwOf[i]));
        got = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (readyOf(i) && !clear) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (got) begin
            @(posedge clk);
            #1;
            lastAccept[i] = cycleCnt;
            modelSum[i]   = modelSum[i] + dot;
            chanCnt[i]++;
            if (chanCnt[i] == chanOf[i]) begin
                expQ[i].push_back(modelResult(modelSum[i], dwOf[i], fracOf[i], cycleCnt));
                modelSum[i] = '0;
                chanCnt[i]  = 0;
            end
        end else begin
            checkOutput($sformatf("accept timeout dut%0d", i), 64'd0, 64'd1);
        end
        driveIn(i, 1'b0, '0, '0);
    endtask

    task automatic waitResult(input int i, input string name, input logic [63:0] expVal,
                              input logic expOvf, input int expLat);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #2;
            if (validOf(i)) begin
                got = 1'b1;
                break;
            end
        end
        if (got) begin
            checkOutput(name, finalOf(i), expVal);
            checkOutput({name, " overflow"}, 64'(ovfOf(i)), 64'(expOvf));
            checkOutput({name, " latency"}, 64'(cycleCnt - lastAccept[i]), 64'(expLat));
        end else begin
            checkOutput({name, " timeout"}, 64'd0, 64'd1);
        end
    endtask

    // Every output cycle is compared against the model's pending result.
    always begin
        @(negedge clk);
        #1;
        if (rst_n && !clear) begin
            for (int i = 0; i < 4; i++) begin
                if (validOf(i)) begin
                    if (expQ[i].size() == 0) begin
                        checkOutput($sformatf("spurious out_valid dut%0d", i), 64'd1, 64'd0);
                    end else begin
                        checkOutput($sformatf("model result dut%0d", i), finalOf(i), expQ[i][0].val);
                        checkOutput($sformatf("model overflow dut%0d", i), 64'(ovfOf(i)),
                                    64'(expQ[i][0].ovf));
                        if (!firstSeen[i]) begin
                            firstSeen[i] = 1'b1;
                            checkOutput($sformatf("model latency dut%0d", i),
                                        64'(cycleCnt - expQ[i][0].acceptCycle), 64'(latOf[i]));
                        end
                        if (outReadyOf(i)) begin
                            void'(expQ[i].pop_front());
                            firstSeen[i] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hs;
        bit got;
        rst_n = 1'b0;
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            driveIn(i, 1'b0, '0, '0);
            setOutReady(i, 1'b1);
            lastAccept[i] = 0;
        end
        flushModel();
        fillWin(0, 0);
        #22;
        rst_n = 1'b1;

        @(negedge clk);
        #1;
        checkOutput("reset in_ready", 64'(readyOf(0)), 64'd1);
        checkOutput("reset out_valid", 64'(validOf(0)), 64'd0);
        checkOutput("reset finalAccumulate", finalOf(0), 64'd0);
        checkOutput("reset overflow", 64'(ovfOf(0)), 64'd0);
        for (int i = 0; i < 4; i++) checkOutput($sformatf("reset busy dut%0d", i), 64'(busyOf(i)), 64'd0);

        fillWin(2, 3);
        applyStimulus(0);
        waitResult(0, "twos by threes", 64'd54, 1'b0, 4);

        fillWin(0, 0);
        winM[0] = -5;
        winC[0] = 7;
        applyStimulus(0);
        waitResult(0, "neg five by seven", 64'hFFFF_FFDD, 1'b0, 4);

        fillWin(1, 1);
        applyStimulus(1);
        repeat (8) @(negedge clk);
        #2;
        checkOutput("busy between channels", 64'(busyOf(1)), 64'd1);
        checkOutput("no out_valid first channel", 64'(validOf(1)), 64'd0);
        checkOutput("ready between channels", 64'(readyOf(1)), 64'd1);
        applyStimulus(1);
        waitResult(1, "two channels", 64'd18, 1'b0, 6);

        setOutReady(0, 1'b0);
        fillWin(1, 1);
        for (int k = 0; k < 9; k++) winM[k] = k + 1;
        applyStimulus(0);
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #2;
            if (validOf(0)) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput("stall reached OUT", 64'(got), 64'd1);
        for (int k = 0; k < 5; k++) begin
            checkOutput("stall out_valid", 64'(validOf(0)), 64'd1);
            checkOutput("stall result", finalOf(0), 64'd45);
            checkOutput("stall in_ready", 64'(readyOf(0)), 64'd0);
            @(negedge clk);
            #2;
        end
        @(negedge clk);
        setOutReady(0, 1'b1);
        @(posedge clk);
        #1;
        hs = cycleCnt;
        fillWin(2, 3);
        applyStimulus(0);
        checkOutput("accept after handshake", 64'(lastAccept[0] - hs), 64'd1);
        waitResult(0, "after stall", 64'd54, 1'b0, 4);

        fillWin(100, 100);
        applyStimulus(2);
`ifdef MA_SATURATE_EN
        waitResult(2, "dw8 saturate", 64'h7F, 1'b1, 4);
`else
        waitResult(2, "dw8 wrap", 64'h90, 1'b1, 4);
`endif

        fillWin(0, 0);
        winM[0] = 32'h0180;
        winC[0] = 32'h0200;
        applyStimulus(3);
        waitResult(3, "fixed point", 64'h300, 1'b0, 4);

        fillWin(3, 3);
        applyStimulus(0);
        @(negedge clk);
        clear = 1'b1;
        driveIn(2, 1'b1, packWin(winM, 8), packWin(winC, 8));
        #2;
        checkOutput("in_ready during clear", 64'(readyOf(0)), 64'd0);
        @(posedge clk);
        #1;
        flushModel();
        driveIn(2, 1'b0, '0, '0);
        @(negedge clk);
        clear = 1'b0;
        #2;
        checkOutput("no accept under clear", 64'(busyOf(2)), 64'd0);
        checkOutput("busy after clear", 64'(busyOf(0)), 64'd0);
        repeat (6) @(negedge clk);
        #2;
        checkOutput("no out_valid after clear", 64'(validOf(0)), 64'd0);

        fillWin(4, 4);
        applyStimulus(0);
        #3;
        rst_n = 1'b0;
        flushModel();
        #1;
        checkOutput("busy in reset", 64'(busyOf(0)), 64'd0);
        checkOutput("out_valid in reset", 64'(validOf(0)), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #2;
        checkOutput("no out_valid after reset", 64'(validOf(0)), 64'd0);
        fillWin(2, 3);
        applyStimulus(0);
        waitResult(0, "clean after reset", 64'd54, 1'b0, 4);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", passCount, totalChecks);
        $finish;
    end

endmodule

// File: doc/ma_conv_engine.md
# ma_conv_engine

Parametrised, handshaked multiply-accumulate engine for convolution windows. It is the successor to the fixed 3x3 / 32-bit integer matrix accelerator. It accepts one flattened KERNEL_SIZE² window pair per transfer and time-multiplexes the products over LANES multipliers. It accumulates across CHANNELS windows, supports integer or fixed-point (FRAC_BITS) results, and returns one narrowed DATA_WIDTH result per output pixel through a valid/ready port.

## Interface
- DATA_WIDTH, 32, signed element and result width (8, 16 or 32)
- KERNEL_SIZE, 3, window edge; window holds N = KERNEL_SIZE² elements
- LANES, 3, multipliers per cycle, 1..N
- CHANNELS, 1, windows accumulated per result, ≥1
- FRAC_BITS, 0, fixed-point fraction bits; 0 = integer mode
- ACC_WIDTH, 2*DATA_WIDTH+$clog2(N*CHANNELS), accumulator width (derived)
- Clk  in  1  single clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous discard of any partial accumulation
- in_valid  in  1  window pair valid
- in_ready  out  1  engine can accept a window
- multiplier_input  in  N*DATA_WIDTH  flat signed operands, element i at [i*DATA_WIDTH +: DATA_WIDTH]
- multiplicand_input  in  N*DATA_WIDTH  flat signed operands, same packing
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- finalAccumulate  out  DATA_WIDTH  narrowed signed result
- overflow  out  1  result exceeded DATA_WIDTH range; qualified by out_valid
- busy  out  1  state ≠ IDLE, or a partial channel sum is held

## Operation
- BEATS = ceil(N/LANES). A partial last beat zero-fills unused lanes.
- States: IDLE, MAC, NARROW, OUT.
- IDLE: in_ready = 1 when clear = 0.
  - On in_valid & in_ready, latch both vectors, set beat = 0, go to MAC.
- MAC: each cycle, acc += sum of the LANES signed full-width products for elements beat*LANES … beat*LANES+LANES-1. Then beat++.
  - After beat BEATS-1: if chan < CHANNELS-1, chan++ and go to IDLE, with acc held. Otherwise go to NARROW.
- NARROW: r = acc >>> FRAC_BITS, an arithmetic shift that truncates toward −∞.
  - Register finalAccumulate from r per the narrowing rule in Configuration.
  - Set overflow = r outside [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1].
  - Go to OUT.
- OUT: out_valid = 1. finalAccumulate and overflow stay stable until out_ready.
  - On out_valid & out_ready: acc = 0, chan = 0, go to IDLE.
- clear: in any state, acc = 0, chan = 0, beat = 0, out_valid = 0, state = IDLE, from the next edge.
  - clear has priority over in_valid and out_ready. No window is accepted in a cycle with clear = 1.
- Reset values: state IDLE, in_ready 1 once Rst_n is high, out_valid 0, finalAccumulate 0, overflow 0, busy 0, acc/chan/beat 0.
- Reset mid-operation: immediate asynchronous return to the reset values. The partial sum is lost and no out_valid is produced.

## Timing
- Window accepted at edge t (last channel). MAC occupies edges t+1 … t+BEATS. NARROW is at edge t+BEATS+1. out_valid is high starting edge t+BEATS+1.
- Latency = BEATS+1 cycles; K=3, LANES=3 gives 4.
- Throughput, no backpressure: one window per BEATS+1 cycles for non-final channels. Add one OUT cycle per result.
- Back-to-back: in_ready returns the cycle after the out handshake. There is no accept/output overlap.
- Non-final channels produce no out_valid pulse.

## Configuration
- MA_SATURATE_EN defined: an out-of-range r clamps to 2^(DATA_WIDTH−1)−1 or −2^(DATA_WIDTH−1).
- MA_SATURATE_EN undefined: finalAccumulate = r[DATA_WIDTH−1:0], two's-complement wrap.
- overflow behaves identically in both builds.

## Structure
- Package ma_pkg holds:
  - the state enum (IDLE, MAC, NARROW, OUT)
  - a beats(N, LANES) ceil function
  - an acc_width function
  - a saturating-narrow function used by NARROW
- Sub-module ma_dot_lane (parameters DATA_WIDTH, LANES): combinational LANES-wide signed product sum, sign-extended to ACC_WIDTH. The top holds all sequential state.

## Test plan
- All multipliers 2, all multiplicands 3 (K=3, LANES=3, CHANNELS=1, FRAC_BITS=0, DW=32):
  - finalAccumulate = 54
  - out_valid exactly 4 cycles after accept
  - overflow = 0
- Element 0 = −5 × 7, all others 0, same configuration: finalAccumulate = 0xFFFFFFDD (−35).
- CHANNELS=2, two windows of all 1×1, LANES=2 (BEATS=5):
  - no out_valid after the first window
  - 18 after the second
  - busy = 1 between the windows
- out_ready held low 5 cycles in OUT:
  - out_valid and finalAccumulate stable
  - in_ready = 0
  - next window accepted the cycle after the handshake
- DW=8, all elements 100×100 (sum 90000):
  - MA_SATURATE_EN build: output 127, overflow 1
  - wrap build: output 0x90 (−112), overflow 1
- DW=16, FRAC_BITS=8, element 0 = 0x0180 × 0x0200, others 0: output 0x0300.
- clear, then Rst_n low, mid-MAC:
  - no out_valid
  - next clean window gives the correct result with no residue
